// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries a DATA_W payload plus a CTRL_W control field under valid/ready,
// with flush (bubble insertion), an optional skid entry that makes in_ready
// a pure register decode, and a saturating bubble-cycle counter.
//
// Handshake: a beat moves on a rising edge where valid && ready are both 1.
// The producer holds valid and payload steady until the beat moves. The
// consumer's ready may depend on anything. out_data/out_ctrl never change
// while out_valid && !out_ready.
module pipe_stage_reg #(
  parameter int unsigned           DATA_W      = 32,
  parameter int unsigned           CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]     BUBBLE_CTRL = '0,
  parameter bit                    ZERO_DATA   = 1'b1,
  parameter bit                    SKID        = 1'b1,
  parameter int unsigned           CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              clr_cnt,
  output logic [1:0]        dbg_state
);

  // EMPTY: nothing held. FULL: main entry valid. SKID_FULL: main + skid valid.
  // With SKID=0 the SKID_FULL state is never entered.
  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_fire;
  logic                out_fire;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Ready/valid decode; with a skid entry in_ready comes only from state_q.
  always_comb begin
    out_valid = (state_q != EMPTY);
    if (SKID) begin
      in_ready = (state_q != SKID_FULL);
    end else begin
      in_ready = out_ready || (state_q == EMPTY);
    end
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    out_data  = data_q;
    out_ctrl  = ctrl_q;
    dbg_state = state_q;
  end

  // Next state and datapath; flush wins over every handshake.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
      ctrl_d  = BUBBLE_CTRL;
      if (ZERO_DATA) begin
        data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            data_d = in_data;
            ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
            ctrl_d  = BUBBLE_CTRL;
            if (ZERO_DATA) begin
              data_d = '0;
            end
          end else if (in_fire) begin
            // Only reachable with a skid entry: main is stalled, park the beat.
            if (SKID) begin
              state_d     = SKID_FULL;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end else begin
              data_d = in_data;
              ctrl_d = in_ctrl;
            end
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            state_d = FULL;
            data_d  = skid_data_q;
            ctrl_d  = skid_ctrl_q;
          end
        end
        default: begin
          state_d = EMPTY;
          ctrl_d  = BUBBLE_CTRL;
          data_d  = '0;
        end
      endcase
    end
  end

  // Bubble counter: clear beats increment, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (!out_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset overrides flush, handshakes and clr_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      ctrl_q      <= BUBBLE_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance a has a skid entry and a 3-bit bubble
// counter, instance b has no skid entry. Each has a FIFO reference model.
module tb_pipe_stage_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance a: SKID=1, CNT_W=3 ----------------
  logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [31:0] a_in_data, a_out_data;
  logic [7:0]  a_in_ctrl, a_out_ctrl;
  logic [2:0]  a_cnt;
  logic [1:0]  a_dbg;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(3)) u_a (
    .clk(clk), .reset(a_reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .bubble_cnt(a_cnt), .clr_cnt(a_clr), .dbg_state(a_dbg)
  );

  // ---------------- instance b: SKID=0, CNT_W=16 ----------------
  logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [31:0] b_in_data, b_out_data;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [15:0] b_cnt;
  logic [1:0]  b_dbg;

  pipe_stage_reg #(.SKID(1'b0)) u_b (
    .clk(clk), .reset(b_reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .bubble_cnt(b_cnt), .clr_cnt(b_clr), .dbg_state(b_dbg)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [39:0] a_exp_q[$];
  logic [39:0] b_exp_q[$];
  logic [2:0]  a_exp_cnt = '0;
  logic [15:0] b_exp_cnt = '0;
  bit          a_armed = 1'b0;
  bit          b_armed = 1'b0;

  // Instance a: a beat is accepted while fewer than two are held.
  always @(negedge clk) begin
    bit in_fire, out_fire;
    if (a_armed) begin
      check("a_out_valid", 64'(a_out_valid), 64'(a_exp_q.size() != 0));
      check("a_in_ready",  64'(a_in_ready),  64'(a_exp_q.size() < 2));
      check("a_cnt",       64'(a_cnt),       64'(a_exp_cnt));
      if (a_exp_q.size() != 0) check("a_payload", 64'({a_out_ctrl, a_out_data}), 64'(a_exp_q[0]));
      else                     check("a_bubble",  64'({a_out_ctrl, a_out_data}), 64'(0));
    end
    if (a_reset) begin
      a_exp_q.delete();
      a_exp_cnt = '0;
      a_armed   = 1'b1;
    end else begin
      if (a_clr) a_exp_cnt = '0;
      else if (a_exp_q.size() == 0 && a_exp_cnt != 3'd7) a_exp_cnt = a_exp_cnt + 3'd1;
      if (a_flush) begin
        a_exp_q.delete();
      end else begin
        in_fire  = a_in_valid && (a_exp_q.size() < 2);
        out_fire = a_out_ready && (a_exp_q.size() != 0);
        if (out_fire) void'(a_exp_q.pop_front());
        if (in_fire)  a_exp_q.push_back({a_in_ctrl, a_in_data});
      end
    end
  end

  // Instance b: ready when downstream ready or nothing held.
  always @(negedge clk) begin
    bit in_fire, out_fire;
    if (b_armed) begin
      check("b_out_valid", 64'(b_out_valid), 64'(b_exp_q.size() != 0));
      check("b_in_ready",  64'(b_in_ready),  64'(b_out_ready || (b_exp_q.size() == 0)));
      check("b_cnt",       64'(b_cnt),       64'(b_exp_cnt));
      if (b_exp_q.size() != 0) check("b_payload", 64'({b_out_ctrl, b_out_data}), 64'(b_exp_q[0]));
      else                     check("b_bubble",  64'({b_out_ctrl, b_out_data}), 64'(0));
    end
    if (b_reset) begin
      b_exp_q.delete();
      b_exp_cnt = '0;
      b_armed   = 1'b1;
    end else begin
      if (b_clr) b_exp_cnt = '0;
      else if (b_exp_q.size() == 0 && b_exp_cnt != 16'hFFFF) b_exp_cnt = b_exp_cnt + 16'd1;
      if (b_flush) begin
        b_exp_q.delete();
      end else begin
        in_fire  = b_in_valid && (b_out_ready || (b_exp_q.size() == 0));
        out_fire = b_out_ready && (b_exp_q.size() != 0);
        if (out_fire) void'(b_exp_q.pop_front());
        if (in_fire)  b_exp_q.push_back({b_in_ctrl, b_in_data});
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] beats[4];
  int          idx;

  initial begin
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;
    {a_reset, a_flush, a_in_valid, a_out_ready, a_clr} = 5'b10000;
    {b_reset, b_flush, b_in_valid, b_out_ready, b_clr} = 5'b10000;
    a_in_data = '0; a_in_ctrl = '0; b_in_data = '0; b_in_ctrl = '0;
    idle(2);
    a_reset = 1'b0; b_reset = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    idle(2);

    // Single beat with 1-cycle latency, then a bubble.
    a_in_valid = 1'b1; a_in_data = 32'h0000_ABCD; a_in_ctrl = 8'h15;
    next_cycle();
    a_in_valid = 1'b0;
    @(negedge clk);
    check("single_valid", 64'(a_out_valid), 64'(1));
    check("single_data",  64'(a_out_data),  64'(32'h0000_ABCD));
    check("single_ctrl",  64'(a_out_ctrl),  64'(8'h15));
    next_cycle();
    @(negedge clk);
    check("single_gone",  64'(a_out_valid), 64'(0));
    check("single_bctrl", 64'(a_out_ctrl),  64'(0));
    next_cycle();

    // Stream four beats with downstream stalled for three cycles.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      a_out_ready = (c >= 3);
      a_in_valid  = (idx < 4);
      a_in_data   = beats[(idx < 4) ? idx : 0];
      a_in_ctrl   = 8'(idx + 1);
      @(negedge clk);
      if (c == 2) check("stall_ready", 64'(a_in_ready), 64'(0));
      if (a_in_valid && a_in_ready) idx++;
      next_cycle();
    end
    check("stream_sent", 64'(idx), 64'(4));

    // Flush while both entries hold data and a new beat is offered.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h66; a_in_ctrl = 8'h06;
    next_cycle();
    a_in_data = 32'h77; a_in_ctrl = 8'h07;
    next_cycle();
    a_in_data = 32'h55; a_in_ctrl = 8'h05; a_flush = 1'b1;
    @(negedge clk);
    check("skidfull_ready", 64'(a_in_ready), 64'(0));
    next_cycle();
    a_flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(a_out_valid), 64'(0));
    check("flush_ready", 64'(a_in_ready),  64'(1));
    check("flush_data",  64'(a_out_data),  64'(0));
    next_cycle();
    a_out_ready = 1'b1;
    idle(3);

    // Reset while FULL, together with flush and clr_cnt.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h99; a_in_ctrl = 8'h09;
    next_cycle();
    a_in_data = 32'hAA; a_in_ctrl = 8'h0A;
    a_reset = 1'b1; a_flush = 1'b1; a_clr = 1'b1;
    next_cycle();
    a_reset = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(a_out_valid), 64'(0));
    check("rst_ctrl",  64'(a_out_ctrl),  64'(0));
    check("rst_data",  64'(a_out_data),  64'(0));
    check("rst_cnt",   64'(a_cnt),       64'(0));
    check("rst_ready", 64'(a_in_ready),  64'(1));
    next_cycle();
    a_out_ready = 1'b1;

    // Counter saturation and clear.
    a_clr = 1'b1;
    next_cycle();
    a_clr = 1'b0;
    idle(10);
    @(negedge clk);
    check("cnt_sat", 64'(a_cnt), 64'(7));
    next_cycle();
    a_clr = 1'b1;
    next_cycle();
    a_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr", 64'(a_cnt), 64'(0));
    next_cycle();
    @(negedge clk);
    check("cnt_inc", 64'(a_cnt), 64'(1));
    next_cycle();

    // No-skid stage: continuous input with out_ready toggling.
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      b_out_ready = (c % 2 == 0);
      b_in_valid  = (idx < 8);
      b_in_data   = 32'h100 + 32'(idx) + (32'($urandom_range(0, 15)) << 16);
      b_in_ctrl   = 8'(idx + 8'h20);
      @(negedge clk);
      if (b_in_valid && b_in_ready) idx++;
      next_cycle();
    end
    check("b_sent", 64'(idx), 64'(8));
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    check("b_drained", 64'(b_out_valid), 64'(0));
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
